// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register, feeding a
// serial bit stream (x / x_valid / last) to a downstream sequence detector.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAPW  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       gap_q, gap_d;

  logic word_done;
  logic gap_done;
  logic transfer;

  assign word_done = (cnt_q == CW'(WIDTH - 1));
  assign gap_done  = (gap_q == 3'(GAP - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    transfer    = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) transfer = 1'b1;
      end
      SHIFT: begin
        if (word_done) begin
          if (GAP == 0) begin
            if (hold_full_q) transfer = 1'b1;
            else             state_d  = IDLE;
          end else begin
            state_d = GAPW;
            gap_d   = '0;
          end
        end else begin
          if (MSB_FIRST != 0) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          else                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAPW: begin
        if (gap_done) begin
          if (hold_full_q) transfer = 1'b1;
          else             state_d  = IDLE;
        end else begin
          gap_d = gap_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (transfer) begin
      shreg_d     = hold_q;
      hold_full_d = 1'b0;
      cnt_d       = '0;
      state_d     = SHIFT;
    end

    // A transfer only happens with hold_full_q=1, so it never races an accepted load.
    if (load && !hold_full_q) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end
  end

  always_comb begin
    ready   = ~hold_full_q;
    x       = 1'b0;
    x_valid = 1'b0;
    last    = 1'b0;
    if (state_q == SHIFT) begin
      x       = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
      x_valid = 1'b1;
      last    = word_done;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: four parameter variants driven with the
// same stimulus, each checked against a time-arithmetic reference model.
module tb_bit_serializer;

  localparam int N = 4;
  localparam int WID   [N] = '{8, 8, 8, 5};
  localparam int GAPS  [N] = '{1, 0, 0, 3};
  localparam int MSBF  [N] = '{1, 1, 0, 0};

  typedef struct {
    int   cyc;
    logic bitv;
    logic lastv;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [31:0]   din = '0;
  logic [N-1:0]  rdy, xo, xv, lst;

  exp_t expq [N][$];
  int   holdBusy [N];
  int   nextFree [N];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   monOn = 1'b0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .GAP(1), .MSB_FIRST(1)) dut0 (
    .clk(clk), .rst(rst), .din(din[7:0]), .load(load),
    .ready(rdy[0]), .x(xo[0]), .x_valid(xv[0]), .last(lst[0]));

  bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .din(din[7:0]), .load(load),
    .ready(rdy[1]), .x(xo[1]), .x_valid(xv[1]), .last(lst[1]));

  bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(0)) dut2 (
    .clk(clk), .rst(rst), .din(din[7:0]), .load(load),
    .ready(rdy[2]), .x(xo[2]), .x_valid(xv[2]), .last(lst[2]));

  bit_serializer #(.WIDTH(5), .GAP(3), .MSB_FIRST(0)) dut3 (
    .clk(clk), .rst(rst), .din(din[4:0]), .load(load),
    .ready(rdy[3]), .x(xo[3]), .x_valid(xv[3]), .last(lst[3]));

  function automatic void check(string name, int i, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, i, cyc, got, exp);
    end
  endfunction

  // Reference model: a word captured at edge C is transferred at
  // max(C+1, previous transfer + WIDTH + GAP); its bits are visible after the
  // WIDTH edges starting at the transfer edge, and ready is low from C until then.
  function automatic void modelEdge(input logic r, input logic l, input logic [31:0] d);
    int tx;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (r) begin
        while (expq[i].size() > 0 && expq[i][expq[i].size()-1].cyc >= cyc)
          void'(expq[i].pop_back());
        holdBusy[i] = cyc;
        nextFree[i] = 0;
      end else if (l && (cyc - 1 >= holdBusy[i])) begin
        tx = (cyc + 1 > nextFree[i]) ? cyc + 1 : nextFree[i];
        for (int k = 0; k < WID[i]; k++) begin
          e.cyc   = tx + k;
          e.bitv  = (MSBF[i] != 0) ? d[WID[i]-1-k] : d[k];
          e.lastv = (k == WID[i] - 1);
          expq[i].push_back(e);
        end
        nextFree[i] = tx + WID[i] + GAPS[i];
        holdBusy[i] = tx;
      end
    end
  endfunction

  task automatic applyStimulus(input logic r, input logic l, input logic [31:0] d);
    rst  = r;
    load = l;
    din  = d;
    @(posedge clk);
    cyc++;
    modelEdge(r, l, d);
    #1;
  endtask

  task automatic checkOutput(input int i);
    exp_t e;
    check("ready", i, 32'(rdy[i]), 32'(cyc >= holdBusy[i]));
    if (expq[i].size() > 0 && expq[i][0].cyc < cyc) begin
      check("stale_bit", i, 32'(expq[i][0].cyc), 32'(cyc));
      void'(expq[i].pop_front());
    end
    if (expq[i].size() > 0 && expq[i][0].cyc == cyc) begin
      e = expq[i].pop_front();
      check("x_valid", i, 32'(xv[i]), 32'd1);
      check("x", i, 32'(xo[i]), 32'(e.bitv));
      check("last", i, 32'(lst[i]), 32'(e.lastv));
    end else begin
      check("idle_outputs", i, {29'd0, xv[i], xo[i], lst[i]}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      for (int i = 0; i < N; i++) checkOutput(i);
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      holdBusy[i] = 0;
      nextFree[i] = 0;
    end

    $display("[TB] reset and quiet period");
    applyStimulus(1'b1, 1'b0, 32'h0);
    monOn = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0);
    idle(5);

    $display("[TB] single word A5");
    applyStimulus(1'b0, 1'b1, 32'hA5);
    idle(14);

    $display("[TB] back-to-back F0 then 0F");
    applyStimulus(1'b0, 1'b1, 32'hF0);
    idle(3);
    applyStimulus(1'b0, 1'b1, 32'h0F);
    idle(24);

    $display("[TB] rejected loads while holding");
    applyStimulus(1'b0, 1'b1, 32'h11);
    applyStimulus(1'b0, 1'b1, 32'hFF);
    idle(2);
    applyStimulus(1'b0, 1'b1, 32'h22);
    applyStimulus(1'b0, 1'b1, 32'hFF);
    idle(3);
    applyStimulus(1'b0, 1'b1, 32'hFF);
    idle(30);

    $display("[TB] mid-word reset");
    applyStimulus(1'b0, 1'b1, 32'hC3);
    idle(1);
    applyStimulus(1'b0, 1'b1, 32'h3C);
    idle(1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    idle(20);

    $display("[TB] single word 01");
    applyStimulus(1'b0, 1'b1, 32'h01);
    idle(16);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 900; n++) begin
      applyStimulus(($urandom_range(99) == 0), ($urandom_range(99) < 35), $urandom);
    end
    idle(40);

    for (int i = 0; i < N; i++) check("queue_drained", i, 32'(expq[i].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the word width in bits; legal range 2..32.
REQ-002 SHALL have parameter GAP, default 1, meaning the idle cycles inserted between words; legal range 0..7.
REQ-003 SHALL have parameter MSB_FIRST, default 1, meaning 1 = MSB shifted first and 0 = LSB shifted first.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port din  input  WIDTH  the parallel word to serialize.
REQ-007 SHALL have port load  input  1  the word-offer strobe; accepted only when ready=1.
REQ-008 SHALL have port ready  output  1  high when the holding register is empty.
REQ-009 SHALL have port x  output  1  the serial bit stream, which feeds the downstream sequence-detector FSM input x.
REQ-010 SHALL have port x_valid  output  1  high while x carries a data bit.
REQ-011 SHALL have port last  output  1  high during the final bit of each word.

Function
REQ-012 SHALL contain a one-entry holding register (hold, hold_full) and a WIDTH-bit shift register with a bit counter.
REQ-013 SHALL drive ready combinationally as ~hold_full, from the registered flag only.
REQ-014 SHALL capture din into hold and set hold_full at the edge where load=1 and ready=1; load with ready=0 SHALL be ignored with no side effects.
REQ-015 SHALL implement states IDLE, SHIFT and GAPW, encoded as registered state.
REQ-016 IDLE: x=0, x_valid=0, last=0; if hold_full, the next edge SHALL transfer hold to the shifter, clear hold_full, zero the bit counter and enter SHIFT.
REQ-017 SHALL give a minimum latency of 2 edges from an accepting load: the edge capturing into hold, then the edge entering SHIFT, after which the first bit is visible.
REQ-018 SHIFT: x SHALL be bit[WIDTH-1] (MSB_FIRST=1) or bit[0] (MSB_FIRST=0) of the shifter; x_valid=1; each edge shifts one position and increments the counter.
REQ-019 last SHALL be 1 exactly when the counter equals WIDTH-1 in SHIFT.
REQ-020 On the edge ending a last bit with GAP=0 and hold_full=1, SHALL reload the shifter from hold, clear hold_full and stay in SHIFT, so x_valid remains continuously 1.
REQ-021 On the edge ending a last bit with GAP=0 and hold_full=0, SHALL go to IDLE.
REQ-022 On the edge ending a last bit with GAP>0, SHALL go to GAPW with the gap counter at 0.
REQ-023 GAPW: x=0, x_valid=0, last=0 for exactly GAP cycles; then, if hold_full, SHALL go directly to SHIFT with a transfer as in REQ-016, else to IDLE.
REQ-024 SHALL allow a load to be accepted in any state while hold_full=0, including during SHIFT and GAPW.
REQ-025 Simultaneous transfer and load SHALL be impossible, because ready=0 whenever hold_full=1; no word is lost or duplicated.
REQ-026 x, x_valid and last SHALL be glitch-free registered-state decodes, with no combinational path from din or load.
REQ-027 The bit counter SHALL be wide enough for WIDTH-1 and SHALL never wrap within a word.

Reset
REQ-028 When rst=1 at a clock edge, SHALL set state=IDLE, hold_full=0, shifter=0, counters=0; rst SHALL take priority over load.
REQ-029 After a reset edge, SHALL drive x=0, x_valid=0, last=0, ready=1.
REQ-030 Reset asserted mid-word SHALL abort the word; the partial word and any held word SHALL be discarded and never resumed.

Verification
REQ-031 SHALL verify reset: rst=1 for 2 cycles, then rst=0 -> x=0, x_valid=0, last=0, ready=1, with no activity for 5 cycles.
REQ-032 SHALL verify a single word (WIDTH=8, GAP=1, MSB_FIRST=1): load din=8'hA5 -> ready=0 for 1 cycle, then x_valid=1 for 8 cycles with x=1,0,1,0,0,1,0,1; last=1 on the 8th; then 1 cycle x_valid=0; then IDLE.
REQ-033 SHALL verify back-to-back words (GAP=0): load 8'hF0, then 8'h0F during bit 3 -> 16 contiguous valid bits 1111000000001111, last=1 on bits 8 and 16, ready low from capture until the reload edge.
REQ-034 SHALL verify a rejected load: with hold_full=1, pulse load with din=8'hFF -> the held word is unchanged and the output stream is unaffected.
REQ-035 SHALL verify mid-word reset: rst=1 after 3 bits of 8'hC3 with 8'h3C held -> next cycle x_valid=0, ready=1, and neither word appears afterwards.
REQ-036 SHALL verify LSB-first ordering: MSB_FIRST=0, load 8'h01 -> x=1,0,0,0,0,0,0,0 with last=1 on the 8th bit.
